// File: rtl/linear_image_filter_pkg.sv
// Shared types, default widths and the output round/saturate helper for the
// linear image filter MAC datapath.
package linear_image_filter_pkg;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } stage_tag_t;

    localparam int DEF_NUM_STAGE  = 3;
    localparam int DEF_DIN0_WIDTH = 32;
    localparam int DEF_DIN1_WIDTH = 32;
    localparam int DEF_ACC_WIDTH  = 72;
    localparam int DEF_DOUT_WIDTH = 32;

    // Widest accumulator / output the helper handles; ACC_WIDTH must stay below RS_ACC_W.
    localparam int RS_ACC_W  = 128;
    localparam int RS_DOUT_W = 64;

    typedef struct packed {
        logic                 sat;
        logic [RS_DOUT_W-1:0] val;
    } rs_t;

    function automatic rs_t round_sat(input logic signed [RS_ACC_W-1:0] sum,
                                      input logic is_signed, input int shift,
                                      input int dout_w);
        logic signed [RS_ACC_W:0] one, r, hi, lo;
        rs_t res;
        one = {{RS_ACC_W{1'b0}}, 1'b1};
        r   = {sum[RS_ACC_W-1], sum};
        if (shift > 0)
            r = r + (one <<< (shift - 1));
        r = r >>> shift;
        if (is_signed) begin
            hi = (one <<< (dout_w - 1)) - one;
            lo = -(one <<< (dout_w - 1));
        end else begin
            hi = (one <<< dout_w) - one;
            lo = '0;
        end
        res.sat = (r > hi) || (r < lo);
        if (r > hi)      res.val = hi[RS_DOUT_W-1:0];
        else if (r < lo) res.val = lo[RS_DOUT_W-1:0];
        else             res.val = r[RS_DOUT_W-1:0];
        return res;
    endfunction

endpackage

// File: rtl/linear_image_filter_mul_pipe.sv
// Stages 1..NUM_STAGE-1: operand registers, signed/unsigned multiplier and
// product pipeline with the window tags carried alongside.
module linear_image_filter_mul_pipe
    import linear_image_filter_pkg::*;
#(
    parameter int NUM_STAGE  = DEF_NUM_STAGE,
    parameter int DIN0_WIDTH = DEF_DIN0_WIDTH,
    parameter int DIN1_WIDTH = DEF_DIN1_WIDTH,
    parameter bit SIGNED     = 1'b0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             ce,
    input  logic                             in_valid,
    input  logic                             in_first,
    input  logic                             in_last,
    input  logic [DIN0_WIDTH-1:0]            din0,
    input  logic [DIN1_WIDTH-1:0]            din1,
    output logic [DIN0_WIDTH+DIN1_WIDTH-1:0] prod,
    output logic                             prod_valid,
    output logic                             prod_first,
    output logic                             prod_last,
    output logic                             vld_any
);
    localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
    localparam int PS = NUM_STAGE - 2;

    logic [DIN0_WIDTH-1:0] a_q;
    logic [DIN1_WIDTH-1:0] b_q;
    stage_tag_t            t1_q;
    logic [PW-1:0]         ext_a, ext_b, prod_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q  <= '0;
            b_q  <= '0;
            t1_q <= '0;
        end else if (ce) begin
            a_q  <= din0;
            b_q  <= din1;
            // first/last only mean something on a live term
            t1_q <= '{valid: in_valid, first: in_valid && in_first, last: in_valid && in_last};
        end
    end

    // Extending both operands to the product width makes one PW-bit multiply exact in both modes.
    assign ext_a  = {{DIN1_WIDTH{SIGNED & a_q[DIN0_WIDTH-1]}}, a_q};
    assign ext_b  = {{DIN0_WIDTH{SIGNED & b_q[DIN1_WIDTH-1]}}, b_q};
    assign prod_c = ext_a * ext_b;

    generate
        if (PS == 0) begin : g_comb
            assign prod       = prod_c;
            assign prod_valid = t1_q.valid;
            assign prod_first = t1_q.first;
            assign prod_last  = t1_q.last;
            assign vld_any    = t1_q.valid;
        end else begin : g_pipe
            logic [PS-1:0][PW-1:0] prod_q;
            stage_tag_t [PS-1:0]   tag_q;
            logic [PS:0]           vld_pipe;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    prod_q <= '0;
                    tag_q  <= '0;
                end else if (ce) begin
                    prod_q[0] <= prod_c;
                    tag_q[0]  <= t1_q;
                    for (int i = 1; i < PS; i++) begin
                        prod_q[i] <= prod_q[i-1];
                        tag_q[i]  <= tag_q[i-1];
                    end
                end
            end

            always_comb begin
                vld_pipe[0] = t1_q.valid;
                for (int i = 0; i < PS; i++)
                    vld_pipe[i+1] = tag_q[i].valid;
            end

            assign vld_any    = |vld_pipe;
            assign prod       = prod_q[PS-1];
            assign prod_valid = tag_q[PS-1].valid;
            assign prod_first = tag_q[PS-1].first;
            assign prod_last  = tag_q[PS-1].last;
        end
    endgenerate

endmodule

// File: rtl/linear_image_filter_mac_pipe.sv
// Pipelined MAC: multiplier pipe plus the window accumulate / round / saturate
// output stage that emits one pixel per kernel window.
module linear_image_filter_mac_pipe
    import linear_image_filter_pkg::*;
#(
    parameter int NUM_STAGE  = DEF_NUM_STAGE,
    parameter int DIN0_WIDTH = DEF_DIN0_WIDTH,
    parameter int DIN1_WIDTH = DEF_DIN1_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int DOUT_WIDTH = DEF_DOUT_WIDTH,
    parameter int SHIFT      = 0,
    parameter bit SIGNED     = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_valid,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  out_sat,
    output logic                  busy
);
    localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

    logic [PW-1:0]        prod;
    logic                 p_valid, p_first, p_last, vld_any;
    logic [ACC_WIDTH-1:0] acc_q, prod_ext, sum;
    logic                 open_q;
    rs_t                  rs;
    logic                 unused_rs;

    linear_image_filter_mul_pipe #(
        .NUM_STAGE (NUM_STAGE),
        .DIN0_WIDTH(DIN0_WIDTH),
        .DIN1_WIDTH(DIN1_WIDTH),
        .SIGNED    (SIGNED)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_last   (in_last),
        .din0      (din0),
        .din1      (din1),
        .prod      (prod),
        .prod_valid(p_valid),
        .prod_first(p_first),
        .prod_last (p_last),
        .vld_any   (vld_any)
    );

    assign prod_ext = {{(ACC_WIDTH-PW){SIGNED & prod[PW-1]}}, prod};
    assign sum      = (p_first ? '0 : acc_q) + prod_ext;

    // The sum is treated as two's complement so the rounding shift is arithmetic.
    always_comb rs = round_sat({{(RS_ACC_W-ACC_WIDTH){sum[ACC_WIDTH-1]}}, sum},
                               SIGNED, SHIFT, DOUT_WIDTH);
    assign unused_rs = ^rs;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q     <= '0;
            open_q    <= 1'b0;
            out_valid <= 1'b0;
            dout      <= '0;
            out_sat   <= 1'b0;
        end else if (ce) begin
            if (p_valid) begin
                acc_q     <= p_last ? '0 : sum;
                open_q    <= !p_last;
                out_valid <= p_last;
                if (p_last) begin
                    dout    <= rs.val[DOUT_WIDTH-1:0];
                    out_sat <= rs.sat;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = vld_any | open_q;

endmodule

// File: tb/tb_linear_image_filter_mac_pipe.sv
// Scoreboarded bench: seven MAC instances (default, signed/SHIFT=4/8-bit,
// SHIFT=1, depths 2/4/5/6) share one stimulus bus, one instance live at a time.
module tb_linear_image_filter_mac_pipe;
    localparam int NI = 7;

    function automatic int cfg_ns(input int k);
        case (k)
            3: return 2;
            4: return 4;
            5: return 5;
            6: return 6;
            default: return 3;
        endcase
    endfunction
    function automatic bit cfg_sg(input int k); return k == 1; endfunction
    function automatic int cfg_sh(input int k); return (k == 1) ? 4 : ((k == 2) ? 1 : 0); endfunction
    function automatic int cfg_dw(input int k); return (k == 1) ? 8 : 32; endfunction

    logic        clk = 1'b0;
    logic        reset, ce, in_valid, in_first, in_last;
    logic [31:0] din0, din1;
    int          sel;
    logic        ov[NI], osat[NI], bsy[NI];
    logic [31:0] dw[NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int DW = cfg_dw(g);
        logic [DW-1:0] d;
        logic          iv;
        assign iv = in_valid && (sel == g);
        linear_image_filter_mac_pipe #(
            .NUM_STAGE (cfg_ns(g)),
            .DIN0_WIDTH(32),
            .DIN1_WIDTH(32),
            .ACC_WIDTH (72),
            .DOUT_WIDTH(DW),
            .SHIFT     (cfg_sh(g)),
            .SIGNED    (cfg_sg(g))
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .ce       (ce),
            .in_valid (iv),
            .in_first (in_first),
            .in_last  (in_last),
            .din0     (din0),
            .din1     (din1),
            .out_valid(ov[g]),
            .dout     (d),
            .out_sat  (osat[g]),
            .busy     (bsy[g])
        );
        assign dw[g] = 32'(d);
    end

    typedef struct {
        int          k;
        logic [31:0] d;
        logic        s;
        longint      due;
    } exp_t;

    exp_t   q[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    longint cedge   = 0;
    longint macc[NI];

    // Reference window model; pushes the expected pixel when a last term is sampled.
    function automatic void model_step(input int k, input bit f, input bit l,
                                       input logic [31:0] a, input logic [31:0] b);
        longint p, s, r, hi, lo;
        int     sh, dwid;
        logic [31:0] mask;
        exp_t   e;
        if (cfg_sg(k)) p = longint'($signed(a)) * longint'($signed(b));
        else           p = longint'({32'b0, a}) * longint'({32'b0, b});
        s = (f ? 64'sd0 : macc[k]) + p;
        macc[k] = l ? 64'sd0 : s;
        if (l) begin
            sh   = cfg_sh(k);
            dwid = cfg_dw(k);
            r    = (sh > 0) ? ((s + (longint'(1) << (sh - 1))) >>> sh) : s;
            if (cfg_sg(k)) begin
                hi = (longint'(1) << (dwid - 1)) - 1;
                lo = -(longint'(1) << (dwid - 1));
            end else begin
                hi = (longint'(1) << dwid) - 1;
                lo = 0;
            end
            e.s = (r > hi) || (r < lo);
            if (r > hi) r = hi;
            if (r < lo) r = lo;
            mask  = 32'hFFFF_FFFF >> (32 - dwid);
            e.d   = 32'(r) & mask;
            e.k   = k;
            e.due = cedge + longint'(cfg_ns(k));
            q.push_back(e);
        end
    endfunction

    task automatic drive(input int k, input bit c, input bit v, input bit f, input bit l,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        sel = k; ce = c; in_valid = v; in_first = f; in_last = l; din0 = a; din1 = b;
        if (c && v) model_step(k, f, l, a, b);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic drain();
        int waited = 0;
        while (q.size() != 0 && waited < 50) begin
            idle(1);
            waited++;
        end
        idle(1);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results still pending, required 0", q.size());
        end
        q.delete();
    endtask

    // Monitor: one comparison per out_valid pulse, counted on ce-enabled edges only.
    always @(posedge clk) begin : mon
        bit   ce_s;
        exp_t e;
        ce_s = ce;
        if (ce_s) cedge++;
        #1;
        if (ce_s) begin
            for (int k = 0; k < NI; k++) begin
                if (ov[k] === 1'b1) begin
                    n_tests++;
                    if (q.size() == 0) begin
                        n_fail++;
                        $display("FAIL out_unexpected inst=%0d dout=%h sat=%b, required no output",
                                 k, dw[k], osat[k]);
                    end else begin
                        e = q.pop_front();
                        if (e.k != k || dw[k] !== e.d || osat[k] !== e.s || cedge != e.due) begin
                            n_fail++;
                            $display("FAIL out_inst%0d dout=%h sat=%b edge=%0d, required inst%0d dout=%h sat=%b edge=%0d",
                                     k, dw[k], osat[k], cedge, e.k, e.d, e.s, e.due);
                        end
                    end
                end
            end
        end
    end

    task automatic check_quiet(input string name, input int k);
        n_tests++;
        if (ov[k] !== 1'b0 || osat[k] !== 1'b0 || bsy[k] !== 1'b0 || dw[k] !== 32'd0) begin
            n_fail++;
            $display("FAIL %s inst=%0d ov=%b sat=%b busy=%b dout=%h, required all 0",
                     name, k, ov[k], osat[k], bsy[k], dw[k]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; ce = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        din0 = '0; din1 = '0; sel = 0;
        for (int k = 0; k < NI; k++) macc[k] = 0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) check_quiet("reset_state", k);
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic test_single_term();
        drive(0, 1, 1, 1, 1, 32'd7, 32'd6);
        idle(1);
        n_tests++;
        if (bsy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_inflight busy=%b, required 1", bsy[0]);
        end
        drive(0, 1, 1, 1, 1, 32'h0001_0000, 32'h0001_0000);
        drain();
        n_tests++;
        if (bsy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_idle busy=%b, required 0", bsy[0]);
        end
    endtask

    task automatic test_nine_tap();
        for (int i = 0; i < 9; i++) drive(1, 1, 1, i == 0, i == 8, 32'd100, 32'd3);
        drain();
        for (int i = 0; i < 9; i++) drive(1, 1, 1, i == 0, i == 8, 32'd100, 32'hFFFF_FFFD);
        drain();
    endtask

    task automatic test_bubbles();
        logic [31:0] a[3] = '{32'd1, 32'd1, 32'd1};
        logic [31:0] b[3] = '{32'd2, 32'd1, 32'd2};
        for (int i = 0; i < 3; i++) drive(2, 1, 1, i == 0, i == 2, a[i], b[i]);
        drain();
        for (int i = 0; i < 3; i++) begin
            drive(2, 1, 1, i == 0, i == 2, a[i], b[i]);
            drive(2, 0, 1, 1, 1, 32'd99, 32'd99);
            drive(2, 1, 0, 1, 1, 32'd77, 32'd77);
            drive(2, 0, 0, 0, 0, 32'd0, 32'd0);
        end
        repeat (4) begin
            drive(2, 1, 0, 0, 0, 32'd0, 32'd0);
            drive(2, 0, 0, 0, 0, 32'd0, 32'd0);
        end
        drain();
    endtask

    task automatic test_restart();
        drive(0, 1, 1, 1, 0, 32'd2, 32'd3);
        idle(5);
        n_tests++;
        if (bsy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_open_window busy=%b, required 1", bsy[0]);
        end
        drive(0, 1, 1, 0, 0, 32'd4, 32'd5);
        drive(0, 1, 1, 1, 0, 32'd1, 32'd10);
        drive(0, 1, 1, 0, 1, 32'd2, 32'd2);
        drain();
        drive(0, 1, 1, 0, 1, 32'd3, 32'd3);
        drain();
        n_tests++;
        if (bsy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_restart busy=%b, required 0", bsy[0]);
        end
    endtask

    task automatic test_async_reset();
        drive(0, 1, 1, 1, 0, 32'd100, 32'd100);
        idle(3);
        drive(0, 1, 1, 1, 1, 32'd5, 32'd5);
        drive(0, 1, 1, 1, 1, 32'd6, 32'd6);
        @(negedge clk);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1 check_quiet("async_reset", 0);
        q.delete();
        for (int k = 0; k < NI; k++) macc[k] = 0;
        @(negedge clk);
        @(negedge clk) reset = 1'b1;
        drive(0, 1, 1, 0, 1, 32'd9, 32'd9);
        drain();
    endtask

    task automatic test_depth_back_to_back();
        int ks[5] = '{0, 3, 4, 5, 6};
        foreach (ks[j]) begin
            for (int i = 0; i < 4; i++)
                drive(ks[j], 1, 1, 1, 1, 32'(i + 1), 32'(ks[j] + 2));
            drain();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_term();
        test_nine_tap();
        test_bubbles();
        test_restart();
        test_async_reset();
        test_depth_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
